core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Per-core control FSM that drives the 3-bit core_state bus consumed by the per-thread PC/NZP units, ALUs, LSUs, fetcher and decoder.
- Sequences each instruction: fetch, decode, memory request/wait, execute, update.
- Owns the core's shared current_pc, reloading it from the threads' next_pc in UPDATE.
- Detects RET and raises done for the block dispatcher.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes in the core
PROGRAM_MEM_ADDR_BITS, 8, width of current_pc and each next_pc

Ports:
clk  in  1  core clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  level; begin executing the block from PC 0
thread_enable  in  THREADS_PER_BLOCK  per-lane active mask, stable while running
fetch_valid  in  1  fetcher has the instruction for current_pc ready
decoded_mem_read_enable  in  1  current instruction is LDR
decoded_mem_write_enable  in  1  current instruction is STR
decoded_ret  in  1  current instruction is RET
lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i]; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
next_pc  in  PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK  per-lane PC-unit output, lane i at slice i
core_state  out  3  current state encoding
current_pc  out  PROGRAM_MEM_ADDR_BITS  shared program counter
done  out  1  block finished, sticky until reset
divergence_error  out  1  sticky lane-PC mismatch flag; tied 0 without the optional feature

Behaviour:
- Reset (async assert, sync-safe deassert): core_state=IDLE, current_pc=0, done=0, divergence_error=0.
- State encodings are fixed; the PC unit decodes EXECUTE=101 and UPDATE=110:
  - IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Transitions:
  - IDLE: start=1 -> FETCH; otherwise hold.
  - FETCH: fetch_valid=1 -> DECODE; otherwise hold with no timeout.
  - DECODE: unconditional, 1 cycle -> REQUEST.
  - REQUEST: unconditional, 1 cycle -> WAIT. LSUs leave IDLE in this state.
  - WAIT, memory instruction (read or write enable): hold while any enabled lane has lsu_state 01 or 10; exit -> EXECUTE once no enabled lane is in 01/10.
  - WAIT, non-memory instruction: exactly 1 cycle -> EXECUTE.
  - EXECUTE: 1 cycle -> UPDATE. PC units register next_pc at the end of this cycle.
  - UPDATE, decoded_ret=1: -> DONE, done<=1, current_pc unchanged.
  - UPDATE, otherwise: current_pc <= next_pc of the lowest-index enabled lane; -> FETCH.
  - DONE: terminal until reset. start is ignored.
- Disabled lanes are ignored for both the WAIT check and the PC select.
- thread_enable=0 (all lanes off): WAIT exits immediately and current_pc takes lane 0's next_pc.
- Latency per non-memory instruction: F+5 cycles, where F is the number of FETCH cycles (F≥1).
- current_pc wraps modulo 2^PROGRAM_MEM_ADDR_BITS; no error is raised.
- start deasserting mid-instruction has no effect; only reset_n aborts execution.
- Async reset mid-WAIT returns to IDLE immediately; outstanding LSU traffic is the LSUs' responsibility.

Optional Feature:
- Macro: CORE_DIVERGENCE_CHECK_EN.
- Defined: in UPDATE with decoded_ret=0, if any two enabled lanes' next_pc differ, then:
  - set divergence_error=1 and done=1;
  - go to DONE;
  - leave current_pc unchanged.
- Undefined: no compare logic; divergence_error is constant 0; the lowest-enabled-lane select still applies.

Decomposition:
- Shared package core_pkg:
  - core_state_t enum with the encodings above;
  - lsu_state_t enum (IDLE/REQUESTING/WAITING/DONE);
  - localparam constants for the state widths.
- The PC unit and other consumers import core_pkg rather than hard-coding 3'b101 / 3'b110.
- One sub-module: thread_pc_select, combinational. It does a priority pick of the lowest enabled lane's next_pc and, under the macro, the all-enabled-lanes-equal compare.

Test Plan:
- Reset, then start=1, fetch_valid high after 2 cycles, non-memory instruction, all next_pc=1 -> state sequence 001,001,010,011,100,101,110,001; current_pc=1 in the cycle after UPDATE.
- LDR, thread_enable=4'b0101, lane0 LSU DONE after 3 WAIT cycles, lane2 after 6, lanes 1/3 stuck at 01 -> exactly 6 WAIT cycles, then EXECUTE.
- UPDATE with decoded_ret=1 and start held high -> DONE, done=1, current_pc unchanged, state held at 111 for 20 cycles.
- thread_enable=4'b1100, next_pc lanes {0x10,0x20,0x30,0x30} -> current_pc=0x30; with macro, lanes {..,0x30,0x31} -> divergence_error=1, done=1, state DONE.
- current_pc=0xFF, next_pc=0x00 -> wraps to 0x00 and fetch continues. Async reset_n pulse mid-WAIT (no clock edge) -> core_state=000 and current_pc=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core-state and LSU-state encodings for the sequencer and every unit that decodes core_state.
// Pure definitions: no logic, no latency, no flow control.
package core_pkg;
  localparam int CORE_STATE_W = 3;
  localparam int LSU_STATE_W  = 2;

  typedef enum logic [CORE_STATE_W-1:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [LSU_STATE_W-1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;
endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer-facing bundle: start/fetch/decode/LSU/PC inputs and state/PC/done outputs.
// Level signals only; stalls are expressed through fetch_valid and per-lane lsu_state.
interface core_sequencer_if #(
  parameter int THREADS   = 4,
  parameter int ADDR_BITS = 8
);
  import core_pkg::*;

  logic                            start;
  logic [THREADS-1:0]              thread_enable;
  logic                            fetch_valid;
  logic                            decoded_mem_read_enable;
  logic                            decoded_mem_write_enable;
  logic                            decoded_ret;
  logic [LSU_STATE_W*THREADS-1:0]  lsu_state;
  logic [ADDR_BITS*THREADS-1:0]    next_pc;
  core_state_t                     core_state;
  logic [ADDR_BITS-1:0]            current_pc;
  logic                            done;
  logic                            divergence_error;

  modport master (
    output start, thread_enable, fetch_valid, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, done, divergence_error
  );

  modport slave (
    input  start, thread_enable, fetch_valid, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, done, divergence_error
  );
endinterface

// File: rtl/thread_pc_select.sv
// Combinational pick of the lowest enabled lane's next_pc (lane 0 if none enabled); zero latency.
// CORE_DIVERGENCE_CHECK_EN adds an all-enabled-lanes-equal compare; otherwise diverged_o is tied 0.
module thread_pc_select #(
  parameter int THREADS   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic [THREADS-1:0]           thread_enable_i,
  input  logic [ADDR_BITS*THREADS-1:0] next_pc_i,
  output logic [ADDR_BITS-1:0]         sel_pc_o,
  output logic                         diverged_o
);

  // Walk high-to-low so the lowest enabled lane is the last write and wins.
  always_comb begin
    sel_pc_o = next_pc_i[ADDR_BITS-1:0];
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (thread_enable_i[i]) sel_pc_o = next_pc_i[i*ADDR_BITS +: ADDR_BITS];
    end
  end

`ifdef CORE_DIVERGENCE_CHECK_EN
  always_comb begin
    diverged_o = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_enable_i[i] && (next_pc_i[i*ADDR_BITS +: ADDR_BITS] != sel_pc_o))
        diverged_o = 1'b1;
    end
  end
`else
  assign diverged_o = 1'b0;
`endif

endmodule

// File: rtl/core_sequencer.sv
// Per-core instruction sequencer: FETCH..UPDATE per instruction (F+5 cycles when not waiting on memory).
// Stalls in FETCH on fetch_valid and in WAIT on busy enabled LSUs; CORE_DIVERGENCE_CHECK_EN enables lane-PC check.
module core_sequencer
  import core_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  core_sequencer_if.slave  bus
);

  core_state_t                      state_q, state_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
  logic                             done_q, done_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] sel_pc;
  logic                             diverged;
  logic                             lsu_busy;
  logic                             mem_instr;

  thread_pc_select #(
    .THREADS   (THREADS_PER_BLOCK),
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS)
  ) u_pc_select (
    .thread_enable_i (bus.thread_enable),
    .next_pc_i       (bus.next_pc),
    .sel_pc_o        (sel_pc),
    .diverged_o      (diverged)
  );

  assign mem_instr = bus.decoded_mem_read_enable | bus.decoded_mem_write_enable;

  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (bus.thread_enable[i] &&
          (bus.lsu_state[LSU_STATE_W*i +: LSU_STATE_W] inside {LSU_REQUESTING, LSU_WAITING}))
        lsu_busy = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    case (state_q)
      CORE_IDLE:    if (bus.start) state_d = CORE_FETCH;
      CORE_FETCH:   if (bus.fetch_valid) state_d = CORE_DECODE;
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT:    if (!(mem_instr && lsu_busy)) state_d = CORE_EXECUTE;
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        if (bus.decoded_ret || diverged) begin
          state_d = CORE_DONE;
          done_d  = 1'b1;
        end else begin
          pc_d    = sel_pc;
          state_d = CORE_FETCH;
        end
      end
      CORE_DONE:    state_d = CORE_DONE;
      default:      state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CORE_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

`ifdef CORE_DIVERGENCE_CHECK_EN
  logic div_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      div_q <= 1'b0;
    else if (state_q == CORE_UPDATE && !bus.decoded_ret && diverged)
      div_q <= 1'b1;
  end

  assign bus.divergence_error = div_q;
`else
  assign bus.divergence_error = 1'b0;
`endif

  assign bus.core_state = state_q;
  assign bus.current_pc = pc_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboarded bench for core_sequencer: driver issues directed and random instructions and queues
// model expectations; monitor checks every retired instruction (next state, PC, flags, cycle counts).
`timescale 1ns/1ps
module tb_core_sequencer;
  import core_pkg::*;

  localparam int T = 4;
  localparam int A = 8;
`ifdef CORE_DIVERGENCE_CHECK_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    int                   f;
    logic                 rd;
    logic                 wr;
    logic                 ret;
    logic [T-1:0][7:0]    t;
    logic [T-1:0][A-1:0]  npc;
  } instr_t;

  typedef struct packed {
    logic [2:0]   st;
    logic [A-1:0] pc;
    logic         done;
    logic         div;
    int           fcyc;
    int           wcyc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if #(.THREADS(T), .ADDR_BITS(A)) bus ();

  core_sequencer #(
    .THREADS_PER_BLOCK     (T),
    .PROGRAM_MEM_ADDR_BITS (A)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  instr_t       prog_q[$];
  exp_t         exp_q[$];
  logic [A-1:0] model_pc = '0;
  int           n_total = 0;
  int           n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference: wait length is the slowest enabled lane (memory ops only), PC from the lowest enabled lane.
  function automatic exp_t model(input instr_t in, input logic [T-1:0] en, input logic [A-1:0] pc);
    exp_t e;
    int   first;
    bit   diff;
    e.fcyc = in.f;
    e.wcyc = 1;
    if (in.rd || in.wr)
      for (int i = 0; i < T; i++)
        if (en[i] && int'(in.t[i]) > e.wcyc) e.wcyc = int'(in.t[i]);
    e.lat = in.f + 4 + e.wcyc;
    first = -1;
    for (int i = 0; i < T; i++) if (en[i] && first < 0) first = i;
    if (first < 0) first = 0;
    diff = 1'b0;
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++)
        if (en[i] && en[j] && in.npc[i] != in.npc[j]) diff = 1'b1;
    e.pc = pc; e.done = 1'b1; e.div = 1'b0; e.st = 3'b111;
    if (!in.ret) begin
      if (DIV_EN && diff) e.div = 1'b1;
      else begin
        e.pc = in.npc[first]; e.done = 1'b0; e.st = 3'b001;
      end
    end
    return e;
  endfunction

  function automatic instr_t mk(input int f, input bit rd, input bit wr, input bit ret, input logic [A-1:0] pc_all);
    instr_t x;
    x = '0;
    x.f = f; x.rd = rd; x.wr = wr; x.ret = ret;
    for (int i = 0; i < T; i++) begin
      x.t[i] = 8'd1;
      x.npc[i] = pc_all;
    end
    return x;
  endfunction

  // Driver: plays fetcher/decoder/LSUs/PC units in response to the observed core_state.
  initial begin : driver
    core_state_t      st, prev;
    int               fk, wk;
    instr_t           cur;
    logic [2*T-1:0]   lv;
    prev = CORE_IDLE; fk = 0; wk = 0; cur = mk(1, 0, 0, 1, '0);
    forever begin
      @(negedge clk);
      st = bus.core_state;
      if (st == CORE_FETCH && prev != CORE_FETCH) begin
        if (prog_q.size() > 0) cur = prog_q.pop_front();
        else cur = mk(1, 0, 0, 1, '0);
        exp_q.push_back(model(cur, bus.thread_enable, model_pc));
        model_pc = exp_q[$].pc;
        fk = 0;
        bus.decoded_mem_read_enable  = cur.rd;
        bus.decoded_mem_write_enable = cur.wr;
        bus.decoded_ret              = cur.ret;
        bus.next_pc                  = cur.npc;
      end
      if (st == CORE_FETCH) begin
        fk++;
        bus.fetch_valid = (fk >= cur.f);
      end else begin
        bus.fetch_valid = 1'b0;
      end
      if (st == CORE_WAIT && prev != CORE_WAIT) wk = 0;
      if (st == CORE_WAIT) wk++;
      for (int i = 0; i < T; i++) begin
        if (!bus.thread_enable[i]) lv[2*i +: 2] = 2'b01;
        else if (st == CORE_REQUEST) lv[2*i +: 2] = 2'b01;
        else if (st == CORE_WAIT) begin
          if (cur.rd || cur.wr) lv[2*i +: 2] = (wk < int'(cur.t[i])) ? 2'b10 : 2'b11;
          else lv[2*i +: 2] = 2'b10;
        end else lv[2*i +: 2] = 2'b00;
      end
      bus.lsu_state = lv;
      prev = st;
    end
  end

  // Monitor: on every exit from UPDATE, pop the oldest expectation and compare.
  initial begin : monitor
    core_state_t st, prev;
    int          fc, wc, lat;
    exp_t        e;
    prev = CORE_IDLE; fc = 0; wc = 0; lat = 0;
    forever begin
      @(negedge clk);
      st = bus.core_state;
      if (!reset_n) begin
        prev = CORE_IDLE;
        continue;
      end
      if (prev == CORE_UPDATE && st != CORE_UPDATE) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: instruction retired with state %0d but no expectation queued", st);
        end else begin
          e = exp_q.pop_front();
          chk("next_state", int'(st), int'(e.st));
          chk("current_pc", int'(bus.current_pc), int'(e.pc));
          chk("done", int'(bus.done), int'(e.done));
          chk("divergence_error", int'(bus.divergence_error), int'(e.div));
          chk("fetch_cycles", fc, e.fcyc);
          chk("wait_cycles", wc, e.wcyc);
          chk("instr_latency", lat, e.lat);
        end
      end
      if (st == CORE_FETCH && prev != CORE_FETCH) begin
        fc = 0; wc = 0; lat = 0;
      end
      if (st == CORE_FETCH) fc++;
      if (st == CORE_WAIT) wc++;
      if (st != CORE_IDLE && st != CORE_DONE) lat++;
      prev = st;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    bus.start = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_state", int'(bus.core_state), 0);
    chk("rst_pc", int'(bus.current_pc), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_div", int'(bus.divergence_error), 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    prog_q.delete();
    model_pc = '0;
    reset_n = 1'b1;
  endtask

  task automatic run_block(input logic [T-1:0] en, input bit keep_start, input bit hold_check);
    bit reached;
    int held;
    bus.thread_enable = en;
    bus.start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.core_state != CORE_IDLE) break;
    end
    if (!keep_start) bus.start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.core_state == CORE_DONE) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) begin
      n_total++;
      $display("FAIL done_timeout: state %0d after 3000 cycles, expected DONE", bus.core_state);
    end
    repeat (2) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    chk("final_done", int'(bus.done), 1);
    chk("final_pc", int'(bus.current_pc), int'(model_pc));
    if (hold_check) begin
      held = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.core_state == CORE_DONE && bus.done) held++;
      end
      chk("done_hold_cycles", held, 20);
    end
  endtask

  initial begin : main
    instr_t x;
    logic [A-1:0] base;
    bit hit;
    bus.start = 1'b0; bus.thread_enable = '0; bus.fetch_valid = 1'b0;
    bus.decoded_mem_read_enable = 1'b0; bus.decoded_mem_write_enable = 1'b0;
    bus.decoded_ret = 1'b0; bus.lsu_state = '0; bus.next_pc = '0;

    // Basic non-memory instruction with a 2-cycle fetch, then RET with start held.
    do_reset();
    prog_q.push_back(mk(2, 0, 0, 0, 8'h01));
    prog_q.push_back(mk(1, 0, 0, 1, 8'h77));
    run_block(4'b1111, 1'b1, 1'b1);

    // LDR with lanes 0/2 enabled: slowest enabled lane sets a 6-cycle WAIT.
    do_reset();
    x = mk(1, 1, 0, 0, 8'h02);
    x.t[0] = 8'd3; x.t[1] = 8'd40; x.t[2] = 8'd6; x.t[3] = 8'd40;
    prog_q.push_back(x);
    prog_q.push_back(mk(1, 0, 0, 1, 8'h00));
    run_block(4'b0101, 1'b0, 1'b0);

    // Lowest enabled lane select; divergent lanes when the check is built in.
    do_reset();
    x = mk(1, 0, 0, 0, 8'h00);
    x.npc[0] = 8'h10; x.npc[1] = 8'h20; x.npc[2] = 8'h30; x.npc[3] = 8'h30;
    prog_q.push_back(x);
    x.npc[3] = 8'h31;
    prog_q.push_back(x);
    prog_q.push_back(mk(1, 0, 0, 1, 8'h00));
    run_block(4'b1100, 1'b0, 1'b0);

    // PC wrap from 0xFF to 0x00, then fetch continues.
    do_reset();
    prog_q.push_back(mk(1, 0, 0, 0, 8'hFF));
    prog_q.push_back(mk(3, 0, 0, 0, 8'h00));
    prog_q.push_back(mk(1, 0, 1, 0, 8'h07));
    prog_q.push_back(mk(1, 0, 0, 1, 8'h00));
    run_block(4'b1111, 1'b0, 1'b0);

    // No lanes enabled: WAIT exits at once even for memory ops, PC comes from lane 0.
    do_reset();
    x = mk(2, 1, 0, 0, 8'h00);
    for (int i = 0; i < T; i++) begin
      x.t[i] = 8'($urandom_range(2, 9));
      x.npc[i] = 8'($urandom);
    end
    x.npc[0] = 8'h42;
    prog_q.push_back(x);
    x.rd = 1'b0; x.wr = 1'b1; x.npc[0] = 8'h43;
    prog_q.push_back(x);
    prog_q.push_back(mk(1, 0, 0, 1, 8'h00));
    run_block(4'b0000, 1'b0, 1'b0);

    // Random program.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      x = mk($urandom_range(1, 4), 0, 0, 0, 8'h00);
      case ($urandom_range(0, 2))
        1: x.rd = 1'b1;
        2: x.wr = 1'b1;
        default: ;
      endcase
      base = A'($urandom);
      for (int i = 0; i < T; i++) begin
        x.t[i] = 8'($urandom_range(1, 6));
        x.npc[i] = ($urandom_range(0, 7) == 0) ? A'($urandom) : base;
      end
      prog_q.push_back(x);
    end
    prog_q.push_back(mk(1, 0, 0, 1, 8'h00));
    run_block(4'($urandom_range(1, 15)), 1'b0, 1'b0);

    // Asynchronous reset in the middle of a long WAIT.
    do_reset();
    prog_q.push_back(mk(1, 0, 0, 0, 8'h55));
    x = mk(1, 1, 0, 0, 8'h66);
    for (int i = 0; i < T; i++) x.t[i] = 8'd10;
    prog_q.push_back(x);
    prog_q.push_back(mk(1, 0, 0, 1, 8'h00));
    bus.thread_enable = 4'b1111;
    bus.start = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.core_state == CORE_WAIT && bus.current_pc == 8'h55) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_wait_pc55", int'(hit), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", int'(bus.core_state), 0);
    chk("async_rst_pc", int'(bus.current_pc), 0);
    chk("async_rst_done", int'(bus.done), 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
